// File: rtl/i2s_transmitter_if.sv
// Sample stream handshake between the tone source and the I2S serialiser.
// The master drives in_valid/in_data; the slave answers with in_ready.
interface i2s_transmitter_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SAMPLE_WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/i2s_transmitter.sv
// Mono-to-stereo I2S serialiser with internal BCLK/LRCLK generation.
// A one-entry holding register prefetches the sample for the next frame.
module i2s_transmitter #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    i2s_transmitter_if.slave    in_if,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underrun
);
    localparam int FRAME = 2 * SLOT_WIDTH;
    localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0]           div_cnt;
    logic [CW-1:0]           bit_cnt;
    logic [CW-1:0]           bit_next;
    logic [CW-1:0]           slot_pos;
    logic [SAMPLE_WIDTH-1:0] hold;
    logic                    hold_full;
    logic [SAMPLE_WIDTH-1:0] frame_sample;
    logic [SAMPLE_WIDTH-1:0] next_sample;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic                    div_wrap;
    logic                    fall;
    logic                    frame_start;
    logic                    slot_start;
    logic                    lr_next;
    logic                    transfer;

    assign in_if.in_ready = ~hold_full;
    assign transfer       = in_if.in_valid & ~hold_full;

    assign div_wrap = (div_cnt == DW'(BCLK_DIV - 1));
    assign fall     = div_wrap & i2s_bclk;

    // Next bit position, slot position and word-select level.
    always_comb begin
        bit_next = bit_cnt + CW'(1);
        if (bit_cnt == CW'(FRAME - 1))
            bit_next = '0;
        slot_pos = bit_next;
        if (bit_next >= CW'(SLOT_WIDTH))
            slot_pos = bit_next - CW'(SLOT_WIDTH);
        lr_next = (bit_next >= CW'(SLOT_WIDTH - 1))
                & (bit_next <= CW'(FRAME - 2));
    end

    assign frame_start = fall & (bit_next == '0);
    assign slot_start  = fall & (slot_pos == '0);

    // Sample for the frame: fetched from the hold register at frame start.
    always_comb begin
        next_sample = frame_sample;
        if (frame_start)
            next_sample = hold_full ? hold : '0;
    end

    // BCLK divider; toggles bclk on every divider wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + DW'(1);
        end
    end

    // Bit counter, word select and serial data advance on BCLK falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt      <= CW'(FRAME - 1);
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            shift_reg    <= '0;
            frame_sample <= '0;
        end else if (fall) begin
            bit_cnt      <= bit_next;
            i2s_lrclk    <= lr_next;
            frame_sample <= next_sample;
            if (slot_start) begin
                i2s_sdata <= next_sample[SAMPLE_WIDTH-1];
                shift_reg <= next_sample << 1;
            end else begin
                i2s_sdata <= shift_reg[SAMPLE_WIDTH-1];
                shift_reg <= shift_reg << 1;
            end
        end
    end

    // Holding register: filled by the handshake, drained at frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (transfer) begin
            hold      <= in_if.in_data;
            hold_full <= 1'b1;
        end else if (frame_start && hold_full) begin
            hold_full <= 1'b0;
        end
    end

    // Underrun flags a frame that starts with nothing to send.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            underrun <= 1'b0;
        else
            underrun <= frame_start & ~hold_full;
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter (BCLK_DIV=2, 32-bit slots, 24-bit data).
// Frame N starts at clk edge 4+256*N after reset release; bit b at +4*b.
module tb_i2s_transmitter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic i2s_bclk, i2s_lrclk, i2s_sdata, underrun;
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;

    i2s_transmitter_if #(.SAMPLE_WIDTH(24)) bus ();

    i2s_transmitter #(
        .SAMPLE_WIDTH(24),
        .SLOT_WIDTH(32),
        .BCLK_DIV(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_if(bus.slave),
        .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Edges since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int   b;
        logic sd;
        logic lr;
    } bit_vec_t;

    bit_vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        while (cyc < n && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (cyc != n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cyc: got %0d required %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic read_frame(input int m, output logic [23:0] l,
                              output logic [23:0] r, output logic u,
                              output logic u1);
        int s;
        s = 4 + 256 * m;
        wait_cyc(s);
        l[23] = i2s_sdata;
        u = underrun;
        wait_cyc(s + 1);
        u1 = underrun;
        for (int b = 1; b < 24; b++) begin
            wait_cyc(s + 4 * b);
            l[23-b] = i2s_sdata;
        end
        for (int b = 0; b < 24; b++) begin
            wait_cyc(s + 4 * (32 + b));
            r[23-b] = i2s_sdata;
        end
    endtask

    logic [23:0] lv, rv;
    logic        uv, u1v;
    int          xfer[4];
    logic [23:0] exp_f[5];
    logic        exp_u[5];

    initial begin
        tbl[0]  = '{0,  1'b1, 1'b0};
        tbl[1]  = '{1,  1'b0, 1'b0};
        tbl[2]  = '{11, 1'b0, 1'b0};
        tbl[3]  = '{22, 1'b0, 1'b0};
        tbl[4]  = '{23, 1'b1, 1'b0};
        tbl[5]  = '{24, 1'b0, 1'b0};
        tbl[6]  = '{30, 1'b0, 1'b0};
        tbl[7]  = '{31, 1'b0, 1'b1};
        tbl[8]  = '{32, 1'b1, 1'b1};
        tbl[9]  = '{40, 1'b0, 1'b1};
        tbl[10] = '{55, 1'b1, 1'b1};
        tbl[11] = '{56, 1'b0, 1'b1};
        tbl[12] = '{62, 1'b0, 1'b1};
        tbl[13] = '{63, 1'b0, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Idle stream: clock patterns, zero data, periodic underrun.
        reset_n = 1'b0;
        #23;
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_lrclk", i2s_lrclk, 0);
        chk("rst_sdata", i2s_sdata, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", bus.in_ready, 1);
        do_reset();
        begin
            int eb, el, es, eu, er;
            eb = 0; el = 0; es = 0; eu = 0; er = 0;
            for (int k = 1; k <= 520; k++) begin
                int  b;
                logic xl, xu;
                wait_cyc(k);
                b  = (k < 4) ? 63 : ((k - 4) / 4) % 64;
                xl = (b >= 31 && b <= 62);
                xu = (k >= 4) && ((k - 4) % 256 == 0);
                if (i2s_bclk !== logic'((k >> 1) & 1)) eb++;
                if (i2s_lrclk !== xl) el++;
                if (i2s_sdata !== 1'b0) es++;
                if (underrun !== xu) eu++;
                if (bus.in_ready !== 1'b1) er++;
            end
            chk("idle_bclk_errs", eb, 0);
            chk("idle_lrclk_errs", el, 0);
            chk("idle_sdata_errs", es, 0);
            chk("idle_underrun_errs", eu, 0);
            chk("idle_ready_errs", er, 0);
        end

        // Single sample 24'h800001 loaded before the first frame.
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h800001;
        do_reset();
        wait_cyc(1);
        bus.in_valid = 1'b0;
        chk("b_ready_after_xfer", bus.in_ready, 0);
        wait_cyc(4);
        chk("b_no_underrun", underrun, 0);
        chk("b_ready_after_start", bus.in_ready, 1);
        for (int i = 0; i < 14; i++) begin
            wait_cyc(4 + 4 * tbl[i].b);
            chk($sformatf("b_sdata_bit%0d", tbl[i].b), i2s_sdata, tbl[i].sd);
            chk($sformatf("b_lrclk_bit%0d", tbl[i].b), i2s_lrclk, tbl[i].lr);
        end
        wait_cyc(260);
        chk("b_next_underrun", underrun, 1);

        // Stream 1,2,3 with valid held, gap frame, then 4.
        exp_f = '{24'h1, 24'h2, 24'h3, 24'h0, 24'h4};
        exp_u = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h1;
        do_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int g;
                    if (i == 3) begin
                        bus.in_valid = 1'b0;
                        wait_cyc(780);
                    end
                    bus.in_data  = 24'(i + 1);
                    bus.in_valid = 1'b1;
                    g = 0;
                    while (!bus.in_ready && g < 2000) begin
                        @(negedge clk);
                        g++;
                    end
                    @(posedge clk);
                    #1;
                    xfer[i] = cyc;
                    chk($sformatf("c_ready_low_%0d", i), bus.in_ready, 0);
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int m = 0; m < 5; m++) begin
                    read_frame(m, lv, rv, uv, u1v);
                    chk($sformatf("c_left_f%0d", m), lv, exp_f[m]);
                    chk($sformatf("c_right_f%0d", m), rv, exp_f[m]);
                    chk($sformatf("c_underrun_f%0d", m), uv, exp_u[m]);
                    chk($sformatf("c_underrun_end_f%0d", m), u1v, 0);
                end
            end
        join
        chk("c_xfer0_cyc", xfer[0], 1);
        chk("c_xfer1_cyc", xfer[1], 5);
        chk("c_xfer2_cyc", xfer[2], 261);
        chk("c_xfer3_cyc", xfer[3], 781);

        // Reset in the right slot while the hold register is full.
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h123456;
        do_reset();
        wait_cyc(1);
        bus.in_data = 24'h654321;
        wait_cyc(5);
        bus.in_valid = 1'b0;
        chk("e_hold_full", bus.in_ready, 0);
        wait_cyc(164);
        chk("e_right_slot", i2s_lrclk, 1);
        reset_n = 1'b0;
        #1;
        chk("e_async_bclk", i2s_bclk, 0);
        chk("e_async_lrclk", i2s_lrclk, 0);
        chk("e_async_sdata", i2s_sdata, 0);
        chk("e_async_underrun", underrun, 0);
        chk("e_async_ready", bus.in_ready, 1);
        do_reset();
        read_frame(0, lv, rv, uv, u1v);
        chk("e_left_zero", lv, 0);
        chk("e_right_zero", rv, 0);
        chk("e_underrun", uv, 1);
        chk("e_underrun_end", u1v, 0);

        // Valid arrives exactly on a frame start with hold empty.
        bus.in_valid = 1'b0;
        do_reset();
        wait_cyc(259);
        bus.in_valid = 1'b1;
        bus.in_data  = 24'hABCDEF;
        wait_cyc(260);
        bus.in_valid = 1'b0;
        chk("f_capture", bus.in_ready, 0);
        read_frame(1, lv, rv, uv, u1v);
        chk("f_underrun", uv, 1);
        chk("f_left_zero", lv, 0);
        read_frame(2, lv, rv, uv, u1v);
        chk("f_left_sample", lv, 24'hABCDEF);
        chk("f_right_sample", rv, 24'hABCDEF);
        chk("f_no_underrun", uv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Downstream stage of the sine generator: consumes 24-bit two's-complement samples over a valid/ready handshake and serialises them as a standard I2S stereo stream (BCLK, LRCLK, SDATA) for the audio codec.
- Each accepted sample is sent on both left and right channels of one frame (mono source).
- Generates all I2S clocks internally from the system clock.
- Contains a one-entry holding register, so the sample for the next frame is fetched while the current frame shifts out.

Parameters:
- SAMPLE_WIDTH, 24: bits per input sample.
- SLOT_WIDTH, 32: BCLK periods per channel slot. Must satisfy SLOT_WIDTH >= SAMPLE_WIDTH.
- BCLK_DIV, 4: clk cycles per BCLK half-period. Must satisfy BCLK_DIV >= 1; BCLK period = 2*BCLK_DIV clk.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  holding register empty; registered.
- in_data  in  SAMPLE_WIDTH  sample, two's complement.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.
- underrun  out  1  one-clk pulse when a frame starts with no sample available.

Behaviour:
- Reset values (async, while reset_n=0):
  - i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0.
  - hold_full=0, so in_ready=1.
  - div_cnt=0, bit_cnt=2*SLOT_WIDTH-1, shift register 0.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - On the wrap, i2s_bclk toggles.
  - A toggle 1->0 is a "falling event". All bit_cnt, lrclk and sdata updates happen only on falling events, in the same clk edge as the BCLK toggle.
- Bit counter: on each falling event, bit_cnt increments modulo 2*SLOT_WIDTH.
- LRCLK (I2S one-bit delay): for the new bit_cnt value b:
  - i2s_lrclk = 1 for b in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2].
  - i2s_lrclk = 0 otherwise (b = 2*SLOT_WIDTH-1 or b < SLOT_WIDTH-1).
- SDATA: for b in slot position p = b mod SLOT_WIDTH:
  - i2s_sdata = sample bit (SAMPLE_WIDTH-1-p) when p < SAMPLE_WIDTH.
  - i2s_sdata = 0 for SAMPLE_WIDTH <= p < SLOT_WIDTH (left-justified, zero padded).
- Frame start is the falling event where bit_cnt wraps to 0:
  - If hold_full=1: the frame sample is taken from the holding register, and hold_full clears on that edge (in_ready=1 on the next cycle).
  - If hold_full=0: the frame sample is 0 and underrun pulses high for exactly that one clk.
  - The frame sample is retained and re-sent for the right slot (b = SLOT_WIDTH).
- Handshake:
  - Transfer occurs when in_valid && in_ready on a clk edge; in_data is captured into hold and hold_full is set.
  - in_ready depends only on hold_full and never on in_valid.
  - in_valid/in_data may be held indefinitely while in_ready=0; no sample is lost or duplicated.
- Simultaneous events: a frame start and an upstream in_valid in the same cycle with hold_full=1 produce no transfer that cycle (in_ready=0); the transfer occurs on a later cycle. A frame start with hold_full=0 and in_valid=1 in the same cycle → underrun fires, the frame sends zeros, and the sample is captured for the next frame.
- Latency: a sample accepted during frame N is output starting at the MSB of frame N+1. The first frame after reset starts at the first falling event, 2*BCLK_DIV clk after reset release.
- Reset mid-frame: all outputs return immediately to their reset values and any held sample is discarded. On release, timing restarts exactly as after power-up.
- Sample rate = f_clk / (4*BCLK_DIV*SLOT_WIDTH). With the defaults: 256 clk per channel slot, 512 clk per frame (100 MHz → ~195 kHz).

Test Plan:
- Parameters BCLK_DIV=2, SLOT_WIDTH=32, SAMPLE_WIDTH=24 (frame = 256 clk) for all scenarios.
- Reset, no input → i2s_bclk period 4 clk; i2s_lrclk period 256 clk, changing only on BCLK falls; i2s_sdata constantly 0; underrun pulses once every 256 clk; in_ready=1.
- Present 24'h800001 before the first frame start → left and right slots each show 1,0x22,1 then 8 zeros; i2s_lrclk fell one BCLK before the MSB; no underrun.
- Hold in_valid=1 with a stream 24'h000001, 24'h000002, 24'h000003 → exactly one transfer per frame; each value appears in consecutive frames in order with no repeats; in_ready=0 between the capture and the next frame start.
- Drop in_valid for one frame mid-stream → that frame carries zeros; underrun is high exactly 1 clk at its start; the stream resumes next frame.
- Assert reset_n=0 mid right slot with hold_full=1 → all outputs reset asynchronously; after release the held sample is gone and the first frame is zero with an underrun pulse.
- Present in_valid=1 in the exact frame-start cycle with hold empty → underrun pulse plus capture that cycle; the sample appears in the following frame.
